// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the multicycle sequencer: opcodes, state
// encodings, trap causes, writeback selects and opcode classification helpers.
package multicycle_ctrl_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I     = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } trap_cause_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } op_class_t;

  function automatic logic opcode_legal(input logic [OPC_W-1:0] opc);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_R, OPC_I, OPC_LUI, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Memory-touching opcodes take the MEM detour; everything else is ALU class.
  function automatic op_class_t opcode_class(input logic [OPC_W-1:0] opc);
    op_class_t cls;
    cls = CLS_ALU;
    case (opc)
      OPC_LOAD:  cls = CLS_LOAD;
      OPC_STORE: cls = CLS_STORE;
      default:   cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mctrl_wait_timer.sv
// Memory-wait watchdog: counts not-ready cycles while a wait state is active
// and flags expiry once the count sits at the limit with ready still low.
module mctrl_wait_timer
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          at_limit_c;

  assign at_limit_c = (cnt_q == CW'(TIMEOUT_CYCLES));
  assign expired_c  = active & ~ready & at_limit_c;

  // Held clear outside wait states, so every entry starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      cnt_q <= '0;
    end else if (!ready && !at_limit_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with illegal-opcode trap and
// retire counter. Define MCTRL_WAIT_TIMEOUT_EN to add the memory-wait timeout trap.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             dec_we,
  input  logic             is_jump,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             alu_en,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_t      state_q, state_next;
  op_class_t   cls_q;
  trap_cause_t cause_c;
  logic        timeout_c;

`ifdef MCTRL_WAIT_TIMEOUT_EN
  logic wait_active_c;
  logic wait_ready_c;

  assign wait_active_c = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_ready_c  = (state_q == ST_FETCH) ? imem_ready : dmem_ready;

  mctrl_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (wait_active_c),
    .ready     (wait_ready_c),
    .expired_c (timeout_c)
  );
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_c          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Opcode class is captured at DECODE so EXEC/MEM/WB steer from a stable copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cls_q <= CLS_ALU;
    end else if (state_q == ST_DECODE) begin
      cls_q <= opcode_class(opcode);
    end
  end

  always_comb begin
    state_next = state_q;
    cause_c    = CAUSE_NONE;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    alu_en     = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);

    case (state_q)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout_c) begin
          cause_c    = CAUSE_TIMEOUT;
          state_next = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (opcode_legal(opcode)) begin
          state_next = ST_EXEC;
        end else begin
          cause_c    = CAUSE_ILLEGAL;
          state_next = ST_TRAP;
        end
      end
      ST_EXEC: begin
        alu_en     = 1'b1;
        state_next = (cls_q == CLS_ALU) ? ST_WB : ST_MEM;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (dmem_ready) begin
          state_next = ST_WB;
        end else if (timeout_c) begin
          cause_c    = CAUSE_TIMEOUT;
          state_next = ST_TRAP;
        end
      end
      ST_WB: begin
        rf_we      = dec_we | (cls_q == CLS_LOAD);
        wb_sel     = is_jump ? WB_PC4 : ((cls_q == CLS_LOAD) ? WB_MEM : WB_ALU);
        pc_we      = 1'b1;
        pc_sel     = is_jump;
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Memory requests fall the moment reset is asserted, not an edge later.
    if (!rst_n) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  // Sticky trap flag and cause, latched on the transition into TRAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else if ((state_q != ST_TRAP) && (state_next == ST_TRAP)) begin
      trap       <= 1'b1;
      trap_cause <= cause_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (state_q == ST_WB) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule
